// File: rtl/sd_kin_ramp_ctrl_if.sv
// rtl/sd_kin_ramp_ctrl_if.sv - retune request handshake bundle for sd_kin_ramp_ctrl
//
// Purpose: carries one retune request (target, step, dwell) from the
// control/register logic to the kin ramp controller.
// Signals:
//   req_valid  requester -> controller  request present, held until accepted
//   req_ready  controller -> requester  controller idle and able to accept
//   req_kval   requester -> controller  target frequency word (16.16 unsigned)
//   req_step   requester -> controller  step per update, 0 = jump to target
//   req_dwell  requester -> controller  extra cycles between updates
// Modports: master = requester side, slave = controller side.
interface sd_kin_ramp_ctrl_if #(
  parameter int BITWIDTH = 32,
  parameter int DWELLW   = 16
);
  logic                req_valid;
  logic                req_ready;
  logic [BITWIDTH-1:0] req_kval;
  logic [BITWIDTH-1:0] req_step;
  logic [DWELLW-1:0]   req_dwell;

  modport master (
    output req_valid,
    output req_kval,
    output req_step,
    output req_dwell,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_kval,
    input  req_step,
    input  req_dwell,
    output req_ready
  );
endinterface

// File: rtl/sd_kin_ramp_ctrl.sv
// rtl/sd_kin_ramp_ctrl.sv - kin frequency-word ramp sequencer for the sigma-delta modulator
//
// Purpose: accepts retune requests and walks kin_out toward each target in
// req_step increments every req_dwell+1 cycles, then holds for SETTLE_CYCLES
// and pulses done. Optional target saturation enabled by macro SD_KIN_CLAMP_EN.
// Ports:
//   clk      single clock
//   reset    synchronous, active-high
//   req      sd_kin_ramp_ctrl_if.slave request handshake (valid/ready + payload)
//   abort    stop the ramp/settle, freeze kin_out, return to IDLE
//   kin_out  registered frequency word to the modulator kin input
//   busy     registered, state is not IDLE
//   done     registered one-cycle pulse when settle completes
//   aborted  registered one-cycle pulse when an abort is taken
module sd_kin_ramp_ctrl #(
  parameter int                BITWIDTH      = 32,
  parameter logic [BITWIDTH-1:0] KRESET      = 32'h082E_6666,
  parameter int                DWELLW        = 16,
  parameter int                SETTLE_CYCLES = 64,
  parameter logic [BITWIDTH-1:0] KMIN        = 32'h0000_0000,
  parameter logic [BITWIDTH-1:0] KMAX        = 32'hFFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  sd_kin_ramp_ctrl_if.slave    req,
  input  logic                 abort,
  output logic [BITWIDTH-1:0]  kin_out,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);

  // One counter serves both dwell and settle, so size it for the larger.
  localparam int SETW = $clog2(SETTLE_CYCLES) + 1;
  localparam int CNTW = (DWELLW > SETW) ? DWELLW : SETW;
  localparam logic [CNTW-1:0] SETTLE_LOAD = CNTW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t              state_q, next_state;
  logic [BITWIDTH-1:0] kin_q, kin_d;
  logic [BITWIDTH-1:0] target_q, target_d;
  logic [BITWIDTH-1:0] step_q, step_d;
  logic [DWELLW-1:0]   dwell_q, dwell_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                ready_q, busy_q, done_q, aborted_q;
  logic                done_d, aborted_d;

  function automatic logic [BITWIDTH-1:0] clamp_k(input logic [BITWIDTH-1:0] k);
    if (k < KMIN)      clamp_k = KMIN;
    else if (k > KMAX) clamp_k = KMAX;
    else               clamp_k = k;
  endfunction

  logic [BITWIDTH-1:0] tgt_in;
`ifdef SD_KIN_CLAMP_EN
  assign tgt_in = clamp_k(req.req_kval);
`else
  assign tgt_in = req.req_kval;
`endif

  logic req_fire, direct, cnt_zero, going_up, lands;
  logic [BITWIDTH-1:0] diff_up, diff_dn, kin_step;

  assign req_fire = (state_q == IDLE) && req.req_valid;
  assign direct   = (req.req_step == '0) || (tgt_in == kin_q);
  assign cnt_zero = (cnt_q == '0);

  // Compare the remaining distance against the step rather than the sum, so
  // the last step lands exactly and kin never wraps past 0 or all-ones.
  assign going_up = (target_q > kin_q);
  assign diff_up  = target_q - kin_q;
  assign diff_dn  = kin_q - target_q;
  always_comb begin
    kin_step = kin_q;
    if (going_up) kin_step = (diff_up <= step_q) ? target_q : kin_q + step_q;
    else          kin_step = (diff_dn <= step_q) ? target_q : kin_q - step_q;
  end
  assign lands = (kin_step == target_q);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= next_state;
  end

  // Next-state logic; abort outranks any update or settle completion.
  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE: begin
        if (req_fire) next_state = direct ? SETTLE : RAMP;
      end
      RAMP: begin
        if (abort)                  next_state = IDLE;
        else if (cnt_zero && lands) next_state = SETTLE;
      end
      SETTLE: begin
        if (abort)         next_state = IDLE;
        else if (cnt_zero) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    kin_d     = kin_q;
    target_d  = target_q;
    step_d    = step_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          target_d = tgt_in;
          step_d   = req.req_step;
          dwell_d  = req.req_dwell;
          if (direct) begin
            kin_d = tgt_in;
            cnt_d = SETTLE_LOAD;
          end else begin
            cnt_d = CNTW'(req.req_dwell);
          end
        end
      end
      RAMP: begin
        if (abort) begin
          aborted_d = 1'b1;
        end else if (cnt_zero) begin
          kin_d = kin_step;
          cnt_d = lands ? SETTLE_LOAD : CNTW'(dwell_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SETTLE: begin
        if (abort)         aborted_d = 1'b1;
        else if (cnt_zero) done_d    = 1'b1;
        else               cnt_d     = cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs; ready/busy follow the state being entered
  // so they are valid on the first cycle of that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      kin_q     <= KRESET;
      target_q  <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      kin_q     <= kin_d;
      target_q  <= target_d;
      step_q    <= step_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      ready_q   <= (next_state == IDLE);
      busy_q    <= (next_state != IDLE);
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign kin_out       = kin_q;
  assign req.req_ready = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;

endmodule

// File: tb/tb_sd_kin_ramp_ctrl.sv
// tb/tb_sd_kin_ramp_ctrl.sv - directed self-checking bench for sd_kin_ramp_ctrl
module tb_sd_kin_ramp_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        abort;
  logic [31:0] kin_out;
  logic        busy, done, aborted;

  sd_kin_ramp_ctrl_if #(.BITWIDTH(32), .DWELLW(16)) rif ();

  sd_kin_ramp_ctrl #(
    .BITWIDTH(32),
    .KRESET(32'h082E_6666),
    .DWELLW(16),
    .SETTLE_CYCLES(64),
    .KMIN(32'h0000_0000),
    .KMAX(32'h0900_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(rif),
    .abort(abort),
    .kin_out(kin_out),
    .busy(busy),
    .done(done),
    .aborted(aborted)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] kval;
    logic [31:0] step;
    logic [15:0] dwell;
    logic [31:0] exp_kin;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Presents a request and returns just after its acceptance edge.
  task automatic send(input logic [31:0] k, input logic [31:0] s, input logic [15:0] d);
    int guard;
    guard = 0;
    while (!rif.req_ready && guard < 300) begin
      tick;
      guard++;
    end
    if (!rif.req_ready) check("send_ready_timeout", 32'(rif.req_ready), 32'd1);
    rif.req_valid = 1'b1;
    rif.req_kval  = k;
    rif.req_step  = s;
    rif.req_dwell = d;
    tick;
    rif.req_valid = 1'b0;
  endtask

  // Counts edges after acceptance until done is seen; -1 if it never comes.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int j = 1; j <= 2000; j++) begin
      tick;
      if (done) begin
        cyc = j;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int n_done;

    // Expected cycles = (updates * (dwell+1)) + 64 settle, or 64 for a direct jump.
    vecs[0] = '{32'h082E_6676, 32'd4,          16'd2, 32'h082E_6676, 76};
    vecs[1] = '{32'h082E_6666, 32'd6,          16'd0, 32'h082E_6666, 67};
    vecs[2] = '{32'h0800_0000, 32'd0,          16'd0, 32'h0800_0000, 64};
    vecs[3] = '{32'h0800_0000, 32'd5,          16'd3, 32'h0800_0000, 64};
    vecs[4] = '{32'h07FF_FFF0, 32'h20,         16'd1, 32'h07FF_FFF0, 66};
    vecs[5] = '{32'h0000_0000, 32'h0500_0000,  16'd0, 32'h0000_0000, 66};
`ifdef SD_KIN_CLAMP_EN
    vecs[6] = '{32'hFFFF_FFFF, 32'h8000_0000,  16'd0, 32'h0900_0000, 65};
    vecs[7] = '{32'hFFFF_0000, 32'd0,          16'd0, 32'h0900_0000, 64};
`else
    vecs[6] = '{32'hFFFF_FFFF, 32'h8000_0000,  16'd0, 32'hFFFF_FFFF, 66};
    vecs[7] = '{32'hFFFF_0000, 32'd0,          16'd0, 32'hFFFF_0000, 64};
`endif

    reset         = 1'b1;
    abort         = 1'b0;
    rif.req_valid = 1'b0;
    rif.req_kval  = '0;
    rif.req_step  = '0;
    rif.req_dwell = '0;
    do_reset;

    // Reset state held while idle
    for (int i = 0; i < 20; i++) begin
      check("idle_kin", kin_out, 32'h082E_6666);
      check("idle_flags", {28'd0, rif.req_ready, busy, done, aborted}, 32'h8);
      tick;
    end

    // Table: chained requests, each starts from the previous final kin
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].kval, vecs[i].step, vecs[i].dwell);
      check($sformatf("vec%0d_busy", i), {30'd0, busy, rif.req_ready}, 32'h2);
      wait_done(cyc);
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      check($sformatf("vec%0d_kin", i), kin_out, vecs[i].exp_kin);
      check($sformatf("vec%0d_ready_on_done", i), 32'(rif.req_ready), 32'd1);
      tick;
      check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // Up ramp edge-by-edge, then abort after the second update
    do_reset;
    send(32'h082E_6676, 32'd4, 16'd2);
    for (int j = 1; j <= 6; j++) begin
      tick;
      if (j == 2) check("ramp_hold_n2", kin_out, 32'h082E_6666);
      if (j == 3) check("ramp_upd_n3", kin_out, 32'h082E_666A);
      if (j == 5) check("ramp_hold_n5", kin_out, 32'h082E_666A);
      if (j == 6) check("ramp_upd_n6", kin_out, 32'h082E_666E);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort_kin", kin_out, 32'h082E_666E);
    check("abort_flags", {29'd0, aborted, rif.req_ready, busy}, 32'h6);
    tick;
    check("abort_pulse_once", 32'(aborted), 32'd0);
    n_done = 0;
    for (int j = 0; j < 100; j++) begin
      if (done) n_done++;
      tick;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_kin_frozen", kin_out, 32'h082E_666E);

    // Reset mid-ramp
    send(32'h082E_7000, 32'd1, 16'd0);
    for (int j = 0; j < 5; j++) tick;
    check("midramp_kin", kin_out, 32'h082E_6673);
    reset = 1'b1;
    tick;
    check("reset_kin", kin_out, 32'h082E_6666);
    check("reset_flags", {28'd0, rif.req_ready, busy, done, aborted}, 32'h8);
    reset = 1'b0;
    tick;

    // Abort together with a request in IDLE: request wins
    abort = 1'b1;
    send(32'h082E_6670, 32'd0, 16'd0);
    abort = 1'b0;
    check("idle_abort_accept", {30'd0, busy, aborted}, 32'h2);
    check("idle_abort_kin", kin_out, 32'h082E_6670);
    wait_done(cyc);
    check("idle_abort_cycles", 32'(cyc), 32'd64);

    // Back-to-back: a held request is taken on the done cycle
    send(32'h082E_6680, 32'd0, 16'd0);
    rif.req_valid = 1'b1;
    rif.req_kval  = 32'h082E_6690;
    rif.req_step  = 32'd0;
    rif.req_dwell = 16'd0;
    wait_done(cyc);
    check("b2b_first_cycles", 32'(cyc), 32'd64);
    check("b2b_first_kin", kin_out, 32'h082E_6680);
    tick;
    rif.req_valid = 1'b0;
    check("b2b_second_kin", kin_out, 32'h082E_6690);
    check("b2b_second_busy", 32'(busy), 32'd1);
    wait_done(cyc);
    check("b2b_second_cycles", 32'(cyc), 32'd64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
